// File: rtl/ec_pkg.sv
// Shared erasure-coding constants and the bitmatrix column memory FSM encoding.
package ec_pkg;
  localparam int K_MAX         = 128;
  localparam int M_MAX         = 128;
  localparam int W             = 4;
  localparam int BM_COL_W      = W * W * K_MAX;
  localparam int BM_MEM_ADDR_W = $clog2(M_MAX);

  typedef enum logic {FILL = 1'b0, COMMIT = 1'b1} bm_mem_state_t;
endpackage

// File: rtl/bm_col_stager.sv
// Assembles one bitmatrix column from host words, checks framing, and holds the
// finished column until the parent finds a free cycle to commit it.
module bm_col_stager
  import ec_pkg::*;
#(
  parameter int COL_W  = BM_COL_W,
  parameter int HDW    = 64,
  parameter int ADDR_W = BM_MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_val,
  output logic              wr_rdy,
  input  logic [HDW-1:0]    wr_data,
  input  logic              wr_last,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              commit_ok,
  output logic              commit,
  output logic              frame_err,
  output logic [COL_W-1:0]  col_data,
  output logic [ADDR_W-1:0] col_addr
);
  localparam int WPC    = COL_W / HDW;
  localparam int WIDX_W = (WPC > 1) ? $clog2(WPC) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WPC - 1);

  bm_mem_state_t     state;
  logic [WIDX_W-1:0] widx;

  assign commit = (state == COMMIT) && commit_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      wr_rdy    <= 1'b1;
      widx      <= '0;
      col_data  <= '0;
      col_addr  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        FILL: if (wr_val) begin
          col_data[widx*HDW +: HDW] <= wr_data;
          // last must coincide exactly with the final word slot, else drop the column
          if (wr_last != (widx == WIDX_LAST)) begin
            frame_err <= 1'b1;
            widx      <= '0;
          end else if (wr_last) begin
            col_addr <= wr_addr;
            state    <= COMMIT;
            wr_rdy   <= 1'b0;
          end else begin
            widx <= widx + 1'b1;
          end
        end
        COMMIT: if (commit_ok) begin
          state  <= FILL;
          wr_rdy <= 1'b1;
          widx   <= '0;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: rtl/bm_mem.sv
// Bitmatrix column memory: host-loaded columns, single-column engine reads with
// 1-cycle latency; reads always win over a pending commit.
module bm_mem #(
  parameter int K_MAX       = ec_pkg::K_MAX,
  parameter int M_MAX       = ec_pkg::M_MAX,
  parameter int W           = ec_pkg::W,
  parameter int HOST_DATA_W = 64,
  localparam int BM_COL_W      = W * W * K_MAX,
  localparam int BM_MEM_ADDR_W = $clog2(M_MAX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_bm_wr_val,
  output logic                     host_bm_wr_rdy,
  input  logic [HOST_DATA_W-1:0]   host_bm_wr_data,
  input  logic                     host_bm_wr_last,
  input  logic [BM_MEM_ADDR_W-1:0] host_bm_wr_addr,
  output logic                     host_bm_wr_err,
  input  logic                     eng_busy,
  input  logic                     bm_cntl_bm_mem_rd_rq,
  input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
  output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
  output logic                     bm_mem_bm_cntl_rd_data_val,
  output logic                     bm_mem_rd_unwritten,
  output logic [M_MAX-1:0]         bm_col_valid
);
  logic                     commit, frame_err, wr_in_range, rd_in_range;
  logic [BM_COL_W-1:0]      col_data;
  logic [BM_MEM_ADDR_W-1:0] col_addr;
  logic [BM_COL_W-1:0]      mem [M_MAX];

  bm_col_stager #(.COL_W(BM_COL_W), .HDW(HOST_DATA_W), .ADDR_W(BM_MEM_ADDR_W)) u_stager (
    .clk       (clk),
    .rst       (rst),
    .wr_val    (host_bm_wr_val),
    .wr_rdy    (host_bm_wr_rdy),
    .wr_data   (host_bm_wr_data),
    .wr_last   (host_bm_wr_last),
    .wr_addr   (host_bm_wr_addr),
    .commit_ok (!eng_busy && !bm_cntl_bm_mem_rd_rq),
    .commit    (commit),
    .frame_err (frame_err),
    .col_data  (col_data),
    .col_addr  (col_addr)
  );

  // A full power-of-two address space has no illegal addresses to screen out.
  generate
    if (M_MAX == (1 << BM_MEM_ADDR_W)) begin : g_pow2
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_npow2
      assign wr_in_range = {1'b0, col_addr} < (BM_MEM_ADDR_W+1)'(M_MAX);
      assign rd_in_range = {1'b0, bm_cntl_bm_mem_rd_addr} < (BM_MEM_ADDR_W+1)'(M_MAX);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (commit && wr_in_range) mem[col_addr] <= col_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bm_mem_bm_cntl_rd_data     <= '0;
      bm_mem_bm_cntl_rd_data_val <= 1'b0;
      bm_mem_rd_unwritten        <= 1'b0;
      bm_col_valid               <= '0;
      host_bm_wr_err             <= 1'b0;
    end else begin
      bm_mem_bm_cntl_rd_data_val <= bm_cntl_bm_mem_rd_rq;
      bm_mem_rd_unwritten        <= 1'b0;
      if (bm_cntl_bm_mem_rd_rq) begin
        bm_mem_bm_cntl_rd_data <= rd_in_range ? mem[bm_cntl_bm_mem_rd_addr] : '0;
        bm_mem_rd_unwritten    <= rd_in_range ? ~bm_col_valid[bm_cntl_bm_mem_rd_addr] : 1'b1;
      end
      if (commit && wr_in_range) bm_col_valid[col_addr] <= 1'b1;
      if (frame_err || (commit && !wr_in_range)) host_bm_wr_err <= 1'b1;
    end
  end
endmodule
